jtpang_paldma: RTL and testbench

Palette DMA engine for the Pang video subsystem. Copies a block of bytes from a ROM/SDRAM slot into palette RAM through the palette RAM's CPU write port, and arbitrates that port with the Z80. It is the writer feeding the colour mixer's palette RAM: the colour mixer only reads, and this block fills it during vertical blank without CPU bus time.

---
 rtl/jtpang_paldma.sv | 157 +++++++++++++++
 tb/tb_jtpang_paldma.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtpang_paldma.sv
// Palette DMA: copies ROM bytes into palette RAM through its CPU write port,
// taking the port from the Z80 while a transfer is in flight.
module jtpang_paldma #(
    parameter int unsigned ROMW       = 17,
    parameter bit          BLANK_ONLY = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    // transfer request
    input  logic            start,
    input  logic [ROMW-1:0] src_addr,
    input  logic [10:0]     dst_addr,
    input  logic            dst_bank,
    input  logic [11:0]     len,
    output logic            busy,
    output logic            done,
    input  logic            LVBL,
    // ROM / SDRAM slot
    output logic [ROMW-1:0] rom_addr,
    output logic            rom_cs,
    input  logic [7:0]      rom_data,
    input  logic            rom_ok,
    // Z80 side of the palette port
    input  logic            cpu_pal_cs,
    input  logic            cpu_wr_n,
    input  logic            cpu_bank,
    input  logic [10:0]     cpu_addr,
    input  logic [7:0]      cpu_dout,
    output logic            cpu_wait,
    // palette RAM port
    output logic            pal_cs,
    output logic            wr_n,
    output logic            pal_bank,
    output logic [10:0]     pal_addr,
    output logic [7:0]      pal_din
);

    localparam int unsigned PALW = 11;
    localparam int unsigned CNTW = 12;
    localparam int unsigned DW   = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_BLK,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t          state_q, state_nx;
    logic [ROMW-1:0] src_q;
    logic [PALW-1:0] dst_q;
    logic            bank_q;
    logic [CNTW-1:0] cnt_q;
    logic [DW-1:0]   buf_q;
    logic            first_q;  // first FETCH cycle: rom_ok still refers to an older request

    logic            fetch_ok;
    assign fetch_ok = !first_q && rom_ok;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_nx = (len == CNTW'(0)) ? ST_DONE : ST_FETCH;
            end
            ST_FETCH: begin
                if (fetch_ok) state_nx = BLANK_ONLY ? ST_WAIT_BLK : ST_WRITE;
            end
            ST_WAIT_BLK: begin
                if (!LVBL) state_nx = ST_WRITE;
            end
            ST_WRITE: begin
                state_nx = (cnt_q == CNTW'(1)) ? ST_DONE : ST_FETCH;
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Transfer address/count registers and the one-byte data buffer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src_q   <= '0;
            dst_q   <= '0;
            bank_q  <= 1'b0;
            cnt_q   <= '0;
            buf_q   <= '0;
            first_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        src_q   <= src_addr;
                        dst_q   <= dst_addr;
                        bank_q  <= dst_bank;
                        cnt_q   <= len;
                        first_q <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    first_q <= 1'b0;
                    if (fetch_ok) buf_q <= rom_data;
                end
                ST_WRITE: begin
                    src_q   <= src_q + ROMW'(1);
                    dst_q   <= dst_q + PALW'(1);  // natural 11-bit wrap, bank kept
                    cnt_q   <= cnt_q - CNTW'(1);
                    first_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Status and ROM request decoded straight from the state register
    assign busy     = (state_q == ST_FETCH) || (state_q == ST_WAIT_BLK) || (state_q == ST_WRITE);
    assign done     = (state_q == ST_DONE);
    assign rom_cs   = (state_q == ST_FETCH);
    assign rom_addr = src_q;

    // Palette port arbitration: DMA owns it while busy, CPU passes through otherwise
    always_comb begin
        pal_cs   = 1'b0;
        wr_n     = 1'b1;
        pal_bank = 1'b0;
        pal_addr = '0;
        pal_din  = '0;
        cpu_wait = 1'b0;
        if (rst_n) begin
            if (busy) begin
                cpu_wait = cpu_pal_cs;
                pal_cs   = (state_q == ST_WRITE);
                wr_n     = (state_q != ST_WRITE);
                pal_bank = bank_q;
                pal_addr = dst_q;
                pal_din  = buf_q;
            end else begin
                pal_cs   = cpu_pal_cs;
                wr_n     = cpu_wr_n;
                pal_bank = cpu_bank;
                pal_addr = cpu_addr;
                pal_din  = cpu_dout;
            end
        end
    end

endmodule

// File: tb/tb_jtpang_paldma.sv
// Bench for jtpang_paldma: one instance with BLANK_ONLY=0, one with BLANK_ONLY=1.
module tb_jtpang_paldma;

    localparam int unsigned ROMW = 17;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, LVBL, start0, start1;
    logic [ROMW-1:0] src_addr;
    logic [10:0]     dst_addr;
    logic            dst_bank;
    logic [11:0]     len;
    logic            cpu_pal_cs, cpu_wr_n, cpu_bank;
    logic [10:0]     cpu_addr;
    logic [7:0]      cpu_dout;

    logic            busy0, done0, rom_cs0, cpu_wait0, pal_cs0, wr_n0, pal_bank0;
    logic [ROMW-1:0] rom_addr0;
    logic [7:0]      rom_data0 = 8'h00, pal_din0;
    logic            rom_ok0 = 1'b0;
    logic [10:0]     pal_addr0;

    logic            busy1, done1, rom_cs1, cpu_wait1, pal_cs1, wr_n1, pal_bank1;
    logic [ROMW-1:0] rom_addr1;
    logic [7:0]      rom_data1 = 8'h00, pal_din1;
    logic            rom_ok1 = 1'b0;
    logic [10:0]     pal_addr1;

    jtpang_paldma #(.ROMW(ROMW), .BLANK_ONLY(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .src_addr(src_addr),
        .dst_addr(dst_addr), .dst_bank(dst_bank), .len(len),
        .busy(busy0), .done(done0), .LVBL(LVBL),
        .rom_addr(rom_addr0), .rom_cs(rom_cs0), .rom_data(rom_data0), .rom_ok(rom_ok0),
        .cpu_pal_cs(cpu_pal_cs), .cpu_wr_n(cpu_wr_n), .cpu_bank(cpu_bank),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_wait(cpu_wait0),
        .pal_cs(pal_cs0), .wr_n(wr_n0), .pal_bank(pal_bank0),
        .pal_addr(pal_addr0), .pal_din(pal_din0)
    );

    jtpang_paldma #(.ROMW(ROMW), .BLANK_ONLY(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .src_addr(src_addr),
        .dst_addr(dst_addr), .dst_bank(dst_bank), .len(len),
        .busy(busy1), .done(done1), .LVBL(LVBL),
        .rom_addr(rom_addr1), .rom_cs(rom_cs1), .rom_data(rom_data1), .rom_ok(rom_ok1),
        .cpu_pal_cs(cpu_pal_cs), .cpu_wr_n(cpu_wr_n), .cpu_bank(cpu_bank),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_wait(cpu_wait1),
        .pal_cs(pal_cs1), .wr_n(wr_n1), .pal_bank(pal_bank1),
        .pal_addr(pal_addr1), .pal_din(pal_din1)
    );

    logic [7:0] mem [0:511];
    int lc0 = 0, lc1 = 0;
    int cyc = 0;
    int n_checks = 0, n_pass = 0;
    int wr0 = 0, wr1 = 0, last_wr0 = 0, last_wr1 = 0;
    logic [19:0] q0 [$];
    logic [19:0] q1 [$];
    logic [19:0] got0, exp0, got1, exp1;

    always @(posedge clk) cyc <= cyc + 1;

    // ROM models: rom_ok one cycle wide, in the second cycle rom_cs is seen high
    always @(posedge clk) begin
        if (!rom_cs0) begin
            lc0 <= 0; rom_ok0 <= 1'b0;
        end else begin
            lc0 <= lc0 + 1; rom_ok0 <= (lc0 == 0); rom_data0 <= mem[rom_addr0[8:0]];
        end
        if (!rom_cs1) begin
            lc1 <= 0; rom_ok1 <= 1'b0;
        end else begin
            lc1 <= lc1 + 1; rom_ok1 <= (lc1 == 0); rom_data1 <= mem[rom_addr1[8:0]];
        end
    end

    // Scoreboard: every DMA write is popped and compared against the queue
    always @(negedge clk) begin
        if (rst_n && busy0 && pal_cs0 && !wr_n0) begin
            n_checks++;
            wr0++;
            last_wr0 = cyc;
            got0 = {pal_bank0, pal_addr0, pal_din0};
            if (q0.size() == 0) begin
                $display("FAIL dma0_write: got bank/addr/data %h, expected no write", got0);
            end else begin
                exp0 = q0.pop_front();
                if (got0 !== exp0) $display("FAIL dma0_write: got %h, expected %h", got0, exp0);
                else n_pass++;
            end
        end
        if (rst_n && busy1 && pal_cs1 && !wr_n1) begin
            n_checks++;
            wr1++;
            last_wr1 = cyc;
            got1 = {pal_bank1, pal_addr1, pal_din1};
            if (q1.size() == 0) begin
                $display("FAIL dma1_write: got bank/addr/data %h, expected no write", got1);
            end else begin
                exp1 = q1.pop_front();
                if (got1 !== exp1) $display("FAIL dma1_write: got %h, expected %h", got1, exp1);
                else n_pass++;
            end
        end
    end

    task automatic cpu_idle();
        cpu_pal_cs = 1'b0; cpu_wr_n = 1'b1; cpu_bank = 1'b0; cpu_addr = '0; cpu_dout = '0;
    endtask

    // Drive one start pulse and push the first npush expected writes
    task automatic start_copy(input int which, input logic [ROMW-1:0] src, input logic [10:0] dst,
                              input logic bank, input int n, input int npush);
        logic [10:0]     d;
        logic [ROMW-1:0] s;
        @(posedge clk); #1;
        src_addr = src; dst_addr = dst; dst_bank = bank; len = 12'(n);
        for (int i = 0; i < npush; i++) begin
            d = dst + 11'(i);
            s = src + ROMW'(i);
            if (which == 0) q0.push_back({bank, d, mem[s[8:0]]});
            else            q1.push_back({bank, d, mem[s[8:0]]});
        end
        if (which == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
    endtask

    task automatic wait_done(input int which, input int max, output bit ok, output int dcyc);
        ok = 1'b0; dcyc = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if ((which == 0 && done0) || (which == 1 && done1)) begin
                ok = 1'b1; dcyc = cyc; break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; LVBL = 1'b1; start0 = 1'b0; start1 = 1'b0;
        src_addr = '0; dst_addr = '0; dst_bank = 1'b0; len = '0;
        cpu_pal_cs = 1'b1; cpu_wr_n = 1'b0; cpu_bank = 1'b1; cpu_addr = 11'h155; cpu_dout = 8'hAA;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy0, done0, rom_cs0, cpu_wait0, busy1} !== 5'b0)
            $display("FAIL reset_status: got %b, expected 00000", {busy0, done0, rom_cs0, cpu_wait0, busy1});
        else n_pass++;
        n_checks++;
        if ({pal_cs0, wr_n0, pal_bank0, pal_addr0, pal_din0, rom_addr0} !== {1'b0, 1'b1, 1'b0, 11'h0, 8'h0, 17'h0})
            $display("FAIL reset_port: got %b%b%b %h %h %h, expected 010 000 00 00000",
                     pal_cs0, wr_n0, pal_bank0, pal_addr0, pal_din0, rom_addr0);
        else n_pass++;
        cpu_idle();
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        bit ok; int dc;
        start_copy(0, 17'h100, 11'h010, 1'b1, 4, 4);
        n_checks++;
        if ({busy0, rom_cs0, rom_addr0} !== {1'b1, 1'b1, 17'h100})
            $display("FAIL basic_start: got busy=%b cs=%b addr=%h, expected 1 1 00100", busy0, rom_cs0, rom_addr0);
        else n_pass++;
        wait_done(0, 200, ok, dc);
        n_checks++;
        if (!ok || dc !== last_wr0 + 1 || busy0 !== 1'b0)
            $display("FAIL basic_done: got ok=%0d done_cyc=%0d busy=%b, expected done at %0d busy 0",
                     ok, dc, busy0, last_wr0 + 1);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (done0 !== 1'b0) $display("FAIL basic_done_pulse: got done=%b, expected 0", done0);
        else n_pass++;
        n_checks++;
        if (q0.size() != 0) $display("FAIL basic_count: got %0d writes missing, expected 0", q0.size());
        else n_pass++;
    endtask

    task automatic test_wrap();
        bit ok; int dc;
        start_copy(0, 17'h1F0, 11'h7FE, 1'b0, 4, 4);
        wait_done(0, 200, ok, dc);
        n_checks++;
        if (!ok || q0.size() != 0)
            $display("FAIL wrap: got done=%0d pending=%0d, expected 1 0", ok, q0.size());
        else n_pass++;
    endtask

    task automatic test_len0();
        start_copy(0, 17'h100, 11'h000, 1'b0, 0, 0);
        n_checks++;
        if ({done0, busy0, rom_cs0} !== 3'b100)
            $display("FAIL len0: got done/busy/cs %b, expected 100", {done0, busy0, rom_cs0});
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (done0 !== 1'b0) $display("FAIL len0_pulse: got done=%b, expected 0", done0);
        else n_pass++;
    endtask

    task automatic test_start_ignored();
        bit ok; int dc; int base; int extra;
        start_copy(0, 17'h100, 11'h400, 1'b1, 4, 4);
        repeat (3) @(posedge clk);
        #1;
        src_addr = 17'h1F0; dst_addr = 11'h500; len = 12'd2; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        wait_done(0, 200, ok, dc);
        base = wr0; extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy0) extra++;
        end
        n_checks++;
        if (!ok || q0.size() != 0 || wr0 != base || extra != 0)
            $display("FAIL start_ignored: got done=%0d pending=%0d extra_wr=%0d busy_cycles=%0d, expected 1 0 0 0",
                     ok, q0.size(), wr0 - base, extra);
        else n_pass++;
    endtask

    task automatic test_cpu();
        bit ok; int dc; int bad_wait; int bad_pass;
        @(posedge clk); #1;
        cpu_pal_cs = 1'b1; cpu_wr_n = 1'b0; cpu_bank = 1'b1; cpu_addr = 11'h020; cpu_dout = 8'h55;
        #1;
        n_checks++;
        if ({pal_cs0, wr_n0, pal_bank0, pal_addr0, pal_din0, cpu_wait0} !== {1'b1, 1'b0, 1'b1, 11'h020, 8'h55, 1'b0})
            $display("FAIL cpu_idle_pass: got %b%b%b %h %h wait=%b, expected 101 020 55 wait=0",
                     pal_cs0, wr_n0, pal_bank0, pal_addr0, pal_din0, cpu_wait0);
        else n_pass++;
        start_copy(0, 17'h100, 11'h300, 1'b0, 2, 2);
        bad_wait = 0; bad_pass = 0; ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done0) begin ok = 1'b1; break; end
            if (busy0 && cpu_wait0 !== 1'b1) bad_wait++;
            if (pal_cs0 && !wr_n0 && pal_addr0 == 11'h020 && pal_din0 == 8'h55) bad_pass++;
        end
        n_checks++;
        if (!ok || bad_wait != 0 || bad_pass != 0)
            $display("FAIL cpu_busy: got done=%0d wait_low=%0d cpu_writes=%0d, expected 1 0 0", ok, bad_wait, bad_pass);
        else n_pass++;
        n_checks++;
        if (cpu_wait0 !== 1'b0 || pal_din0 !== 8'h55)
            $display("FAIL cpu_after: got wait=%b din=%h, expected 0 55", cpu_wait0, pal_din0);
        else n_pass++;
        cpu_idle();
    endtask

    task automatic test_blank();
        bit ok; int dc; int early;
        LVBL = 1'b1;
        start_copy(1, 17'h100, 11'h080, 1'b1, 3, 3);
        early = 0;
        repeat (50) begin
            @(negedge clk);
            if (pal_cs1) early++;
        end
        n_checks++;
        if (early != 0 || busy1 !== 1'b1)
            $display("FAIL blank_hold: got pal_cs cycles=%0d busy=%b, expected 0 1", early, busy1);
        else n_pass++;
        @(posedge clk); #1;
        LVBL = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({pal_cs1, wr_n1} !== 2'b10)
            $display("FAIL blank_first_write: got cs/wr_n %b, expected 10", {pal_cs1, wr_n1});
        else n_pass++;
        wait_done(1, 200, ok, dc);
        n_checks++;
        if (!ok || q1.size() != 0 || dc !== last_wr1 + 1)
            $display("FAIL blank_done: got done=%0d pending=%0d cyc=%0d, expected 1 0 %0d", ok, q1.size(), dc, last_wr1 + 1);
        else n_pass++;
        LVBL = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit ok; int dc; int base; int busy_seen;
        base = wr0;
        start_copy(0, 17'h180, 11'h040, 1'b1, 8, 2);
        for (int i = 0; i < 200 && wr0 < base + 2; i++) begin
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        cpu_pal_cs = 1'b1; cpu_wr_n = 1'b0; cpu_bank = 1'b1; cpu_addr = 11'h020; cpu_dout = 8'h55;
        #1;
        n_checks++;
        if ({pal_cs0, wr_n0, cpu_wait0, pal_din0} !== {1'b0, 1'b1, 1'b0, 8'h00})
            $display("FAIL reset_gate: got cs/wr_n/wait %b din %h, expected 010 00", {pal_cs0, wr_n0, cpu_wait0}, pal_din0);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cpu_idle();
        #1;
        n_checks++;
        if ({busy0, done0, rom_cs0, cpu_wait0, pal_cs0, wr_n0, pal_bank0, pal_addr0, pal_din0, rom_addr0}
                !== {4'b0000, 1'b0, 1'b1, 1'b0, 11'h0, 8'h0, 17'h0})
            $display("FAIL reset_mid_state: got busy=%b done=%b cs=%b wait=%b rom_addr=%h pal=%b%b%b %h %h",
                     busy0, done0, rom_cs0, cpu_wait0, rom_addr0, pal_cs0, wr_n0, pal_bank0, pal_addr0, pal_din0);
        else n_pass++;
        busy_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy0) busy_seen++;
        end
        n_checks++;
        if (busy_seen != 0 || wr0 != base + 2 || q0.size() != 0)
            $display("FAIL reset_mid_quiet: got busy cycles=%0d writes=%0d pending=%0d, expected 0 2 0",
                     busy_seen, wr0 - base, q0.size());
        else n_pass++;
        start_copy(0, 17'h104, 11'h600, 1'b0, 2, 2);
        wait_done(0, 200, ok, dc);
        n_checks++;
        if (!ok || q0.size() != 0)
            $display("FAIL reset_restart: got done=%0d pending=%0d, expected 1 0", ok, q0.size());
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'(i * 7 + 3);
        mem[9'h100] = 8'h0F; mem[9'h101] = 8'hA5; mem[9'h102] = 8'h3C; mem[9'h103] = 8'h00;
        mem[9'h1F0] = 8'h12; mem[9'h1F1] = 8'h34; mem[9'h1F2] = 8'h56; mem[9'h1F3] = 8'h78;
        test_reset();
        test_basic();
        test_wrap();
        test_len0();
        test_start_ignored();
        test_cpu();
        test_blank();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
